// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs decoded instruction fields into 9-bit words, buffers them in a
// small FIFO and writes them to instruction memory at consecutive addresses, ending with HALT.
`default_nettype none

module instr_stream_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        IN_OPCODE,
  input  logic [3:0]        IN_REG,
  input  logic              IN_LASTBIT,
  input  logic              IN_LAST,
  input  logic              MEM_STALL,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [8:0]        MEM_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [ADDR_W:0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HALT_WR = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              error_q, error_d;
  logic              saw_halt_q, saw_halt_d;
  // Set once the top address has been written; any further write would wrap.
  logic              ovf_q, ovf_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [8:0]        fifo_mem_q [DEPTH];

  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       in_ready;
  logic       mem_write;
  logic [8:0] mem_data;
  logic [8:0] enc_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Control-class opcodes carry no operand, so their low five bits are canonicalised to 0.
  always_comb begin
    enc_word = {IN_OPCODE, IN_REG, IN_LASTBIT};
    case (IN_OPCODE)
      4'd0, 4'd8, 4'd11, 4'd12, 4'd13: enc_word = {IN_OPCODE, 5'b00000};
      default:                         enc_word = {IN_OPCODE, IN_REG, IN_LASTBIT};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    error_d    = error_q;
    saw_halt_d = saw_halt_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in_ready   = 1'b0;
    push       = 1'b0;
    mem_write  = 1'b0;
    mem_data   = 9'h000;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_LOAD;
          addr_d     = BASE_ADDR;
          count_d    = '0;
          error_d    = 1'b0;
          saw_halt_d = 1'b0;
          ovf_d      = 1'b0;
        end
      end

      ST_LOAD, ST_DRAIN: begin
        in_ready = (state_q == ST_LOAD) && !fifo_full;
        push     = in_ready && IN_VALID;
        if (push) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (IN_LAST || (IN_OPCODE == 4'd0)) begin
            state_d    = ST_DRAIN;
            saw_halt_d = (IN_OPCODE == 4'd0);
          end
        end

        if (!fifo_empty) begin
          if (ovf_q) begin
            // Address space exhausted with words still pending: abort and flush.
            error_d  = 1'b1;
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            mem_data  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
            mem_write = !MEM_STALL;
            if (mem_write) begin
              rd_ptr_d = rd_ptr_q + 1'b1;
              addr_d   = addr_q + 1'b1;
              count_d  = count_q + 1'b1;
              if (&addr_q) begin
                ovf_d = 1'b1;
              end
            end
          end
        end else if (state_q == ST_DRAIN) begin
          if (saw_halt_q) begin
            state_d = ST_DONE;
          end else if (ovf_q) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HALT_WR;
          end
        end
      end

      ST_HALT_WR: begin
        mem_write = !MEM_STALL;
        if (mem_write) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      saw_halt_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      error_q    <= error_d;
      saw_halt_q <= saw_halt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end
  end

  assign IN_READY  = in_ready;
  assign MEM_WRITE = mem_write;
  assign MEM_DATA  = mem_data;
  assign MEM_ADDR  = addr_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign ERROR     = error_q;
  assign COUNT     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: one 10-bit-address instance for the normal
// sessions and one 4-bit-address instance for the address-overflow case.
`default_nettype none

module tb_instr_stream_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic [9:0] base_addr = '0;
  logic [3:0] base4 = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_opcode = '0;
  logic [3:0] in_reg = '0;
  logic       in_lastbit = 1'b0;
  logic       in_last = 1'b0;
  logic       mem_stall = 1'b0;

  logic        in_ready, mem_write, busy, done, error;
  logic [9:0]  mem_addr;
  logic [8:0]  mem_data;
  logic [10:0] count;

  logic       in_ready4, mem_write4, busy4, done4, error4;
  logic [3:0] mem_addr4;
  logic [8:0] mem_data4;
  logic [4:0] count4;

  logic sel4 = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  int acc_cnt = 0;

  logic [18:0] log_q[$];
  logic [18:0] log4_q[$];
  logic [18:0] exp_q[$];

  instr_stream_loader #(.DEPTH(4), .ADDR_W(10)) dut (
    .CLK(clk), .RESET(rst), .START(start), .BASE_ADDR(base_addr),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OPCODE(in_opcode), .IN_REG(in_reg),
    .IN_LASTBIT(in_lastbit), .IN_LAST(in_last), .MEM_STALL(mem_stall),
    .MEM_WRITE(mem_write), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data),
    .BUSY(busy), .DONE(done), .ERROR(error), .COUNT(count)
  );

  instr_stream_loader #(.DEPTH(4), .ADDR_W(4)) dut4 (
    .CLK(clk), .RESET(rst), .START(start4), .BASE_ADDR(base4),
    .IN_VALID(in_valid), .IN_READY(in_ready4), .IN_OPCODE(in_opcode), .IN_REG(in_reg),
    .IN_LASTBIT(in_lastbit), .IN_LAST(in_last), .MEM_STALL(mem_stall),
    .MEM_WRITE(mem_write4), .MEM_ADDR(mem_addr4), .MEM_DATA(mem_data4),
    .BUSY(busy4), .DONE(done4), .ERROR(error4), .COUNT(count4)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge, so the falling edge sees settled outputs.
  always @(negedge clk) begin
    if (mem_write)  log_q.push_back({mem_addr, mem_data});
    if (mem_write4) log4_q.push_back({6'b0, mem_addr4, mem_data4});
    if (done)  done_cnt++;
    if (done4) done4_cnt++;
    if (in_valid && (sel4 ? in_ready4 : in_ready)) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    log4_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    done4_cnt = 0;
    acc_cnt   = 0;
  endtask

  task automatic do_start(input logic [9:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic do_start4(input logic [3:0] base);
    start4 = 1'b1;
    base4 = base;
    tick();
    start4 = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] op, input logic [3:0] rg,
                           input logic lb, input logic lst);
    int n;
    in_valid = 1'b1;
    in_opcode = op;
    in_reg = rg;
    in_lastbit = lb;
    in_last = lst;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel4 ? in_ready4 : in_ready) break;
      n++;
      if (n > 50) begin
        check("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sel4 ? busy4 : busy) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic expect_w(input logic [9:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_log(input string tag);
    logic [18:0] got;
    int nlog;
    nlog = sel4 ? log4_q.size() : log_q.size();
    check({tag, "_nwords"}, nlog, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < nlog) got = sel4 ? log4_q[i] : log_q[i];
      check($sformatf("%s_w%0d", tag, i), {13'd0, got}, {13'd0, exp_q[i]});
    end
  endtask

  task automatic run_s1(input string tag);
    clear_logs();
    do_start(10'h010);
    send_beat(4'd9, 4'd3, 1'b1, 1'b0);
    send_beat(4'd1, 4'd2, 1'b0, 1'b0);
    send_beat(4'd7, 4'd4, 1'b1, 1'b1);
    wait_idle(tag);
    tick();
    expect_w(10'h010, 9'h127);
    expect_w(10'h011, 9'h024);
    expect_w(10'h012, 9'h0E9);
    expect_w(10'h013, 9'h000);
    check_log(tag);
    check({tag, "_count"}, count, 32'd4);
    check({tag, "_done"}, done_cnt, 32'd1);
    check({tag, "_error"}, error, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_write", mem_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", count, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Scenario 1: pass-through encodings plus appended HALT
    run_s1("s1");

    // Scenario 2: canonicalised opcode, then an opcode-0 beat ends the program
    clear_logs();
    do_start(10'h020);
    send_beat(4'd11, 4'd5, 1'b1, 1'b0);
    send_beat(4'd0, 4'd7, 1'b1, 1'b0);
    wait_idle("s2");
    tick();
    expect_w(10'h020, 9'h160);
    expect_w(10'h021, 9'h000);
    check_log("s2");
    check("s2_count", count, 32'd2);
    check("s2_done", done_cnt, 32'd1);

    // Scenario 3: stalled memory fills the FIFO; readiness drops after four accepts
    clear_logs();
    mem_stall = 1'b1;
    do_start(10'h100);
    send_beat(4'd1, 4'd1, 1'b1, 1'b0);
    send_beat(4'd2, 4'd2, 1'b0, 1'b0);
    send_beat(4'd3, 4'd3, 1'b1, 1'b0);
    send_beat(4'd12, 4'd15, 1'b1, 1'b0);
    @(negedge clk);
    check("s3_ready_full", in_ready, 0);
    check("s3_no_write", mem_write, 0);
    check("s3_accepts", acc_cnt, 32'd4);
    tick();
    tick();
    mem_stall = 1'b0;
    send_beat(4'd14, 4'd15, 1'b1, 1'b0);
    send_beat(4'd6, 4'd6, 1'b0, 1'b1);
    wait_idle("s3");
    tick();
    expect_w(10'h100, 9'h023);
    expect_w(10'h101, 9'h044);
    expect_w(10'h102, 9'h067);
    expect_w(10'h103, 9'h180);
    expect_w(10'h104, 9'h1DF);
    expect_w(10'h105, 9'h0CC);
    expect_w(10'h106, 9'h000);
    check_log("s3");
    check("s3_count", count, 32'd7);
    check("s3_done", done_cnt, 32'd1);

    // Scenario 4: address overflow on a 4-bit address space
    sel4 = 1'b1;
    clear_logs();
    do_start4(4'hE);
    send_beat(4'd9, 4'd1, 1'b0, 1'b0);
    send_beat(4'd9, 4'd2, 1'b0, 1'b1);
    wait_idle("s4");
    tick();
    expect_w(10'h00E, 9'h122);
    expect_w(10'h00F, 9'h124);
    check_log("s4");
    check("s4_error", error4, 1);
    check("s4_busy", busy4, 0);
    check("s4_done", done4_cnt, 32'd0);
    check("s4_count", count4, 32'd2);
    do_start4(4'h0);
    check("s4_error_clr", error4, 0);
    send_beat(4'd1, 4'd1, 1'b1, 1'b1);
    wait_idle("s4b");
    tick();
    check("s4b_done", done4_cnt, 32'd1);
    check("s4b_count", count4, 32'd2);
    sel4 = 1'b0;

    // Scenario 5: reset with two words buffered, then a clean rerun of scenario 1
    clear_logs();
    mem_stall = 1'b1;
    do_start(10'h010);
    send_beat(4'd9, 4'd3, 1'b1, 1'b0);
    send_beat(4'd1, 4'd2, 1'b0, 1'b0);
    check("s5_pre_addr", mem_addr, 32'h010);
    mem_stall = 1'b0;
    rst = 1'b1;
    #1;
    check("s5_write", mem_write, 0);
    check("s5_busy", busy, 0);
    check("s5_addr", mem_addr, 0);
    check("s5_data", mem_data, 0);
    check("s5_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("s5_nlog", log_q.size(), 32'd0);
    run_s1("s5r");

    // Scenario 6: START with a beat in IDLE is not a handshake; START in LOAD is ignored
    clear_logs();
    start = 1'b1;
    base_addr = 10'h030;
    in_valid = 1'b1;
    in_opcode = 4'd9;
    in_reg = 4'd3;
    in_lastbit = 1'b1;
    in_last = 1'b0;
    @(negedge clk);
    check("s6_idle_ready", in_ready, 0);
    tick();
    start = 1'b0;
    send_beat(4'd9, 4'd3, 1'b1, 1'b0);
    start = 1'b1;
    base_addr = 10'h200;
    tick();
    start = 1'b0;
    send_beat(4'd7, 4'd4, 1'b1, 1'b1);
    wait_idle("s6");
    tick();
    expect_w(10'h030, 9'h127);
    expect_w(10'h031, 9'h0E9);
    expect_w(10'h032, 9'h000);
    check_log("s6");
    check("s6_accepts", acc_cnt, 32'd2);
    check("s6_count", count, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
